// File: rtl/wm_front_panel.sv
// wm_front_panel: input conditioning in front of the washing-machine controller.
// Synchronises and debounces lid, cancel, coin and six program buttons, latches
// the one-hot program selection and keeps the coin credit with charge/refund.
// Build option: define WM_FRONT_PANEL_DEBOUNCE_EN to include the debouncers;
// without it the debounced level is the synchroniser output (2-clock latency).
module wm_front_panel #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PRICE           = 3,
    parameter int unsigned CREDIT_W        = 4,
    parameter logic [2:0]  IDLE_STATE      = 3'd0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                raw_Lid,
    input  logic                raw_Cancel,
    input  logic                raw_Coin,
    input  logic [5:0]          raw_Program,
    input  logic [2:0]          state,
    output logic                sig_Lid_Closed,
    output logic                sig_Cancel,
    output logic                sig_Coin,
    output logic                input1,
    output logic                input2,
    output logic                input3,
    output logic                input4,
    output logic                input5,
    output logic                input6,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_Refund,
    output logic [CREDIT_W-1:0] refund_Amount
);
    // Bit map of the conditioned vector: 0 lid, 1 cancel, 2 coin, 8:3 program.
    localparam int NB = 9;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;
    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);

    logic [NB-1:0]       raw_vec;
    logic [NB-1:0]       sync_a;
    logic [NB-1:0]       sync_b;
    logic [NB-1:0]       level;
    logic [NB-1:0]       level_d;
    logic [NB-1:0]       rise;
    logic                cancel_edge;
    logic                coin_edge;
    logic [5:0]          prog_edge;
    logic [5:0]          prog;
    logic [5:0]          prog_nxt;
    logic [2:0]          prev_state;
    logic                idle;
    logic                start;
    logic [CREDIT_W-1:0] credit_nxt;
    logic                refund_nxt;
    logic [CREDIT_W-1:0] amount_nxt;

    assign raw_vec = {raw_Program, raw_Coin, raw_Cancel, raw_Lid};

    // Two-flop synchroniser for every asynchronous raw input.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw_vec;
            sync_b <= sync_a;
        end
    end

`ifdef WM_FRONT_PANEL_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CNT_W-1:0] db_cnt [NB];

    // Per-bit debouncer: flip the level after DEBOUNCE_CYCLES disagreeing samples in a row.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
            for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (sync_b[i] != level[i]) begin
                    if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        level[i]  <= sync_b[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign level = sync_b;
`endif

    assign rise           = level & ~level_d;
    assign cancel_edge    = rise[1];
    assign coin_edge      = rise[2];
    assign prog_edge      = rise[8:3];
    assign idle           = (state == IDLE_STATE);
    assign start          = (prev_state == IDLE_STATE) && (state != IDLE_STATE);
    assign sig_Lid_Closed = level[0];
    assign sig_Coin       = (credit >= PRICE_C);
    assign {input6, input5, input4, input3, input2, input1} = prog;

    // Program latch: only in idle, lowest-index rising edge wins.
    always_comb begin
        prog_nxt = prog;
        if (idle && (prog_edge != 6'd0)) begin
            prog_nxt = prog_edge & (~prog_edge + 6'd1);
        end
    end

    // Credit update in priority order: start charge, cancel refund, coin accept.
    always_comb begin
        credit_nxt = credit;
        refund_nxt = 1'b0;
        amount_nxt = refund_Amount;
        if (start) begin
            credit_nxt = (credit >= PRICE_C) ? credit - PRICE_C : '0;
        end
        if (cancel_edge && idle && ((credit != '0) || coin_edge)) begin
            // A coin landing with the refund goes back with it (unless the counter is full).
            refund_nxt = 1'b1;
            credit_nxt = '0;
            amount_nxt = (coin_edge && (credit != CREDIT_MAX)) ? credit + 1'b1 : credit;
        end else if (coin_edge) begin
            if (credit_nxt == CREDIT_MAX) begin
                refund_nxt = 1'b1;
                amount_nxt = CREDIT_W'(1);
            end else begin
                credit_nxt = credit_nxt + 1'b1;
            end
        end
    end

    // Edge history, previous controller state, and all registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_d       <= '0;
            prev_state    <= '0;
            sig_Cancel    <= 1'b0;
            prog          <= 6'b000001;
            credit        <= '0;
            coin_Refund   <= 1'b0;
            refund_Amount <= '0;
        end else begin
            level_d       <= level;
            prev_state    <= state;
            sig_Cancel    <= cancel_edge;
            prog          <= prog_nxt;
            credit        <= credit_nxt;
            coin_Refund   <= refund_nxt;
            refund_Amount <= amount_nxt;
        end
    end

endmodule

// File: tb/tb_wm_front_panel.sv
// Scoreboard bench for wm_front_panel: stimulus pushes expected output events,
// a negedge monitor pops and compares whenever an output changes or pulses.
module tb_wm_front_panel;
`ifdef WM_FRONT_PANEL_DEBOUNCE_EN
    localparam int L = 6;
`else
    localparam int L = 2;
`endif
    localparam int K_LID = 0, K_PROG = 1, K_CREDIT = 2, K_REFUND = 3, K_CANCEL = 4;

    typedef struct {
        int kind;
        int val;
        int aux;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       raw_Lid = 1'b0, raw_Cancel = 1'b0, raw_Coin = 1'b0;
    logic [5:0] raw_Program = 6'd0;
    logic [2:0] state = 3'd0;
    logic       sig_Lid_Closed, sig_Cancel, sig_Coin;
    logic       input1, input2, input3, input4, input5, input6;
    logic [3:0] credit, refund_Amount;
    logic       coin_Refund;

    ev_t  exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    logic       prev_lid = 1'b0;
    logic [5:0] prev_prog = 6'b000001;
    logic [3:0] prev_credit = 4'd0;

    wm_front_panel dut (
        .clock(clock), .reset_n(reset_n),
        .raw_Lid(raw_Lid), .raw_Cancel(raw_Cancel), .raw_Coin(raw_Coin),
        .raw_Program(raw_Program), .state(state),
        .sig_Lid_Closed(sig_Lid_Closed), .sig_Cancel(sig_Cancel), .sig_Coin(sig_Coin),
        .input1(input1), .input2(input2), .input3(input3),
        .input4(input4), .input5(input5), .input6(input6),
        .credit(credit), .coin_Refund(coin_Refund), .refund_Amount(refund_Amount)
    );

    always #5 clock = ~clock;

    task automatic push(input int kind, input int val, input int aux);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.aux  = aux;
        exp_q.push_back(e);
    endtask

    task automatic push_credit(input int val, input int coin_flag);
        push(K_CREDIT, val, coin_flag);
    endtask

    task automatic sb_check(input int kind, input int val, input int aux, input string name);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: unexpected event got val %0d aux %0d, required no event", name, val, aux);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || e.aux != aux) begin
                fails++;
                $display("FAIL %s: got kind %0d val %0d aux %0d, required kind %0d val %0d aux %0d",
                         name, kind, val, aux, e.kind, e.val, e.aux);
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int req);
        tests++;
        if (got != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic coin_pulse();
        raw_Coin = 1'b1;
        wait_neg(L + 2);
        raw_Coin = 1'b0;
        wait_neg(L + 2);
    endtask

    task automatic cancel_press();
        raw_Cancel = 1'b1;
        wait_neg(L + 2);
        raw_Cancel = 1'b0;
        wait_neg(L + 2);
    endtask

    task automatic prog_press(input logic [5:0] p);
        raw_Program = p;
        wait_neg(L + 2);
        raw_Program = 6'd0;
        wait_neg(L + 2);
    endtask

    // Monitor: every output change or pulse must match the head of the queue.
    always @(negedge clock) begin
        if (mon_en) begin
            if (sig_Lid_Closed !== prev_lid) begin
                sb_check(K_LID, int'(sig_Lid_Closed), 0, "lid");
                prev_lid = sig_Lid_Closed;
            end
            if ({input6, input5, input4, input3, input2, input1} !== prev_prog) begin
                sb_check(K_PROG, int'({input6, input5, input4, input3, input2, input1}), 0, "prog");
                prev_prog = {input6, input5, input4, input3, input2, input1};
            end
            if (credit !== prev_credit) begin
                sb_check(K_CREDIT, int'(credit), int'(sig_Coin), "credit");
                prev_credit = credit;
            end
            if (coin_Refund === 1'b1) sb_check(K_REFUND, int'(refund_Amount), 0, "refund");
            if (sig_Cancel === 1'b1) sb_check(K_CANCEL, 1, 0, "cancel");
        end
    end

    initial begin
        // Reset values
        wait_neg(3);
        chk("rst_lid", int'(sig_Lid_Closed), 0);
        chk("rst_cancel", int'(sig_Cancel), 0);
        chk("rst_coin", int'(sig_Coin), 0);
        chk("rst_prog", int'({input6, input5, input4, input3, input2, input1}), 1);
        chk("rst_credit", int'(credit), 0);
        chk("rst_refund", int'(coin_Refund), 0);
        chk("rst_amount", int'(refund_Amount), 0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        wait_neg(20);
        chk("idle_credit", int'(credit), 0);
        chk("idle_prog", int'({input6, input5, input4, input3, input2, input1}), 1);

        // Lid bounce then hold closed
`ifdef WM_FRONT_PANEL_DEBOUNCE_EN
        push(K_LID, 1, 0);
`else
        for (int i = 0; i <= 10; i++) push(K_LID, (i % 2 == 0) ? 1 : 0, 0);
`endif
        for (int i = 0; i < 10; i++) begin
            raw_Lid = (i % 2 == 0);
            wait_neg(1);
        end
        raw_Lid = 1'b1;
        wait_neg(L - 1);
        chk("lid_early", int'(sig_Lid_Closed), 0);
        wait_neg(1);
        chk("lid_rise", int'(sig_Lid_Closed), 1);
        wait_neg(4);

        // Three coins then start charge
        push_credit(1, 0); coin_pulse();
        push_credit(2, 0); coin_pulse();
        push_credit(3, 1); coin_pulse();
        chk("coin_level", int'(sig_Coin), 1);
        push_credit(0, 0);
        state = 3'd1;
        wait_neg(1);
        chk("start_charge", int'(credit), 0);
        state = 3'd0;
        wait_neg(3);

        // Cancel refund in idle, then cancel while running, then idle cancel with no credit
        push_credit(1, 0); coin_pulse();
        push_credit(2, 0); coin_pulse();
        push_credit(0, 0);
        push(K_REFUND, 2, 0);
        push(K_CANCEL, 1, 0);
        cancel_press();
        chk("refund_hold", int'(refund_Amount), 2);
        state = 3'd2;
        push(K_CANCEL, 1, 0);
        cancel_press();
        state = 3'd0;
        wait_neg(2);
        push(K_CANCEL, 1, 0);
        cancel_press();

        // Program selection
        push(K_PROG, 6'b000010, 0);
        prog_press(6'b000010);
        push(K_PROG, 6'b000001, 0);
        prog_press(6'b000101);
        state = 3'd3;
        prog_press(6'b001000);
        state = 3'd0;
        wait_neg(2);
        push(K_PROG, 6'b010000, 0);
        prog_press(6'b110000);
        chk("prog_final", int'({input6, input5, input4, input3, input2, input1}), 6'b010000);

        // Saturation: 15 coins, 16th is returned
        for (int i = 1; i <= 15; i++) begin
            push_credit(i, (i >= 3) ? 1 : 0);
            coin_pulse();
        end
        push(K_REFUND, 1, 0);
        coin_pulse();
        chk("sat_credit", int'(credit), 15);
        chk("sat_amount", int'(refund_Amount), 1);

        // Empty to zero, build credit 5, then coin and start in the same cycle
        push_credit(0, 0);
        push(K_REFUND, 15, 0);
        push(K_CANCEL, 1, 0);
        cancel_press();
        for (int i = 1; i <= 5; i++) begin
            push_credit(i, (i >= 3) ? 1 : 0);
            coin_pulse();
        end
        push_credit(3, 1);
        raw_Coin = 1'b1;
        wait_neg(L);
        state = 3'd1;
        wait_neg(1);
        chk("coin_and_start", int'(credit), 3);
        wait_neg(L + 2);
        raw_Coin = 1'b0;
        wait_neg(L + 2);
        state = 3'd0;
        wait_neg(10);

        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wm_front_panel.md
# wm_front_panel

Input-conditioning stage that sits directly upstream of the washing-machine `Microcontroller`. It synchronises and debounces the raw lid switch, cancel button, coin-acceptor pulse and six program buttons. It then produces the controller's `sig_Lid_Closed`, `sig_Cancel`, `sig_Coin` and one-hot `input1`..`input6` inputs. It also keeps a coin credit counter that is charged when a cycle starts and refunded on cancel while idle.

## Interface
- `DEBOUNCE_CYCLES`, 4 — consecutive stable synchronised samples needed before a debounced level changes (≥1).
- `PRICE`, 3 — coins required per wash cycle (1 ≤ PRICE ≤ 2^CREDIT_W−1).
- `CREDIT_W`, 4 — credit counter width.
- `IDLE_STATE`, 3'd0 — controller `state` encoding meaning idle/awaiting start.

Ports:
- `clock` in 1 — system clock, rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `raw_Lid` in 1 — lid switch, 1 = closed, asynchronous, bouncy.
- `raw_Cancel` in 1 — cancel button, 1 = pressed, asynchronous.
- `raw_Coin` in 1 — coin-acceptor pulse, asynchronous, ≥ (DEBOUNCE_CYCLES+2) clocks wide.
- `raw_Program` in 6 — program buttons, bit k selects program k+1.
- `state` in 3 — current controller state.
- `sig_Lid_Closed` out 1 — debounced lid level.
- `sig_Cancel` out 1 — one-cycle pulse on debounced cancel press.
- `sig_Coin` out 1 — level, 1 when credit ≥ PRICE.
- `input1`..`input6` out 1 each — latched one-hot program selection.
- `credit` out CREDIT_W — current coin credit.
- `coin_Refund` out 1 — one-cycle pulse when coins are returned.
- `refund_Amount` out CREDIT_W — coins returned, valid while `coin_Refund`=1 and held until the next refund.

## Operation
- Every raw input passes through a 2-flop synchroniser, then a per-bit debouncer. A debouncer holds a count of cycles where the synchronised sample ≠ current debounced level. When the count reaches DEBOUNCE_CYCLES the level flips and the count clears. Any agreeing sample clears the count.
- Edge detection uses debounced levels: rising edges of cancel, coin and each program bit.
- Program latch:
  - In idle (`state`==IDLE_STATE), a program rising edge loads the one-hot selection.
  - Simultaneous edges: lowest index wins.
  - Edges outside idle are ignored.
- Credit, evaluated in this priority order each cycle:
  1. Start charge: `state` transitions from IDLE_STATE to any other value (registered previous state) → credit −= PRICE. Clamp at 0 if credit < PRICE.
  2. Cancel refund: cancel edge while idle with credit > 0 → `refund_Amount` = credit, credit = 0, `coin_Refund` pulses.
  3. Coin accept: a coin edge adds 1. At 2^CREDIT_W−1 the coin is not counted; `coin_Refund` pulses with `refund_Amount`=1.
- Coin and start in the same cycle → credit − PRICE + 1.
- Coin and cancel-refund in the same cycle → the coin is included in `refund_Amount` and credit = 0.
- Cancel outside idle: `sig_Cancel` is forwarded, credit is unchanged.
- `sig_Coin` = (credit ≥ PRICE), computed from the registered credit.

## Timing
- Reset values:
  - `sig_Lid_Closed`=0, `sig_Cancel`=0, `sig_Coin`=0.
  - `input1`=1, `input2`..`input6`=0.
  - `credit`=0, `coin_Refund`=0, `refund_Amount`=0.
  - All synchronisers, debouncers and the previous-state register cleared.
- Debounced level changes 2+DEBOUNCE_CYCLES clocks after a clean raw edge.
- Edge pulses, the program latch and the credit update land one clock after the debounced level.
- `sig_Coin` follows the credit update in the same cycle the credit register changes.
- Start charge is applied one clock after `state` leaves IDLE_STATE.
- Reset mid-debounce or mid-refund: everything returns to reset values immediately; no pulse is emitted after release until a fresh debounced edge.

## Configuration
- `WM_FRONT_PANEL_DEBOUNCE_EN` defined: debouncers present as above.
- Not defined: debouncers are removed and debounced level = synchroniser output. Latency is 2 clocks; `DEBOUNCE_CYCLES` is ignored.

## Test plan
- Reset: hold `reset_n`=0 → all outputs at reset values, `input1`=1. Release with all raw inputs 0 → outputs unchanged for 20 clocks.
- Bounce: toggle `raw_Lid` 0/1 every clock for 10 clocks, then hold 1 → `sig_Lid_Closed` rises exactly 6 clocks after the hold begins (defaults); no earlier toggles.
- Credit and start, PRICE=3: three coin pulses → credit 3, `sig_Coin`=1. Drive `state` 0→1 → one clock later credit 0, `sig_Coin`=0.
- Cancel refund: two coins, press cancel in idle → `coin_Refund` one-cycle pulse, `refund_Amount`=2, credit 0. The same cancel with `state`=2 → `sig_Cancel` pulse, no refund.
- Program select: press `raw_Program`=6'b000101 in idle → `input1`=1 only. Press bit 3 with `state`=3 → selection unchanged.
- Saturation and simultaneity: 15 coins, then a 16th → credit 15, `coin_Refund` with `refund_Amount`=1. With credit 5, coin edge and idle→run in the same cycle → credit 3.
